// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if
//   Bundles the byte-stream input and the instruction-memory word-write port
//   of the program loader.
//   Stream : in_byte, in_valid (source -> loader), in_ready (loader -> source)
//   Memory : mem_we, mem_addr, mem_wdata, mem_be (loader -> memory)
//   slave  : the loader's view
//   master : the view of the surrounding boot logic / memory
interface instr_mem_loader_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    modport slave (
        input  in_byte, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output in_byte, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Writer side of the little-endian, word-aligned instruction memory. Packs a
//   byte stream into 32-bit words (byte k of a word -> address aligned+k) and
//   issues one word write per packed word; a short final word is written with
//   only its filled byte enables set and zeros in the unfilled lanes.
// Ports
//   clk, rst         clock; synchronous active-low reset
//   start            begin a load (honoured only in IDLE/DONE)
//   base_addr        image start byte address, low two bits ignored
//   byte_count       image length in bytes
//   bus (slave)      byte stream in + memory write port out
//   busy             load in progress
//   done             load finished, held until next start/reset
//   chk_err          checksum mismatch of the last load
// Optional feature (macro LOADER_CHECKSUM_EN)
//   When defined, one trailing checksum byte is consumed after the data; the
//   load fails (chk_err=1) unless data bytes + checksum sum to 0 mod 256.
//   When undefined there is no trailing byte and chk_err is always 0.
module instr_mem_loader #(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [COUNT_WIDTH-1:0] byte_count,
    instr_mem_loader_if.slave      bus,
    output logic                   busy,
    output logic                   done,
    output logic                   chk_err
);

    // Keeps addresses inside the implemented memory and word-aligned.
    localparam logic [31:0] AMASK =
        32'((64'd1 << ADDR_WIDTH) - 64'd1) & 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE
    } state_t;

    state_t                 state;
    logic [31:0]            addr;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [1:0]             lane;
    logic [3:0][7:0]        wbuf;      // unfilled lanes stay zero
    logic [7:0]             sum;
    logic [3:0][7:0]        word_next;
    logic [3:0]             be_next;
    logic                   xfer;

    assign xfer = bus.in_valid & bus.in_ready;

    // Word as it will look once the byte on the bus is added to it.
    always_comb begin
        word_next       = wbuf;
        word_next[lane] = bus.in_byte;
        be_next         = 4'((5'd2 << lane) - 5'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            addr          <= '0;
            remaining     <= '0;
            lane          <= '0;
            wbuf          <= '0;
            sum           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            chk_err       <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr      <= base_addr & AMASK;
                        remaining <= byte_count;
                        lane      <= '0;
                        wbuf      <= '0;
                        sum       <= '0;
                        done      <= 1'b0;
                        chk_err   <= 1'b0;
                        if (byte_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            // An empty image still carries its checksum byte.
                            state        <= S_CHECK;
                            bus.in_ready <= 1'b1;
                            busy         <= 1'b1;
`else
                            state <= S_DONE;
                            done  <= 1'b1;
`endif
                        end else begin
                            state        <= S_COLLECT;
                            bus.in_ready <= 1'b1;
                            busy         <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (xfer) begin
                        wbuf[lane] <= bus.in_byte;
                        lane       <= lane + 2'd1;
                        remaining  <= remaining - COUNT_WIDTH'(1);
                        sum        <= sum + bus.in_byte;
                        // Word full or image exhausted: present the write next cycle.
                        if (lane == 2'd3 || remaining == COUNT_WIDTH'(1)) begin
                            state         <= S_WRITE;
                            bus.in_ready  <= 1'b0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= addr;
                            bus.mem_wdata <= word_next;
                            bus.mem_be    <= be_next;
                        end
                    end
                end

                S_WRITE: begin
                    bus.mem_we <= 1'b0;
                    addr       <= (addr + 32'd4) & AMASK;
                    lane       <= '0;
                    wbuf       <= '0;
                    if (remaining != '0) begin
                        state        <= S_COLLECT;
                        bus.in_ready <= 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state        <= S_CHECK;
                        bus.in_ready <= 1'b1;
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end

                S_CHECK: begin
                    // Checksum byte is consumed but never written to memory.
                    if (xfer) begin
                        state        <= S_DONE;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        chk_err      <= (8'(sum + bus.in_byte) != 8'd0);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
